// File: rtl/ripple_count_monitor.sv
// Synchronizes the async_counter ripple bus into the clock domain, filters ripple,
// publishes a stable count and keeps a saturating total of counted events.
module ripple_count_monitor #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int ACC_WIDTH     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 clear,
  output logic [WIDTH-1:0]     count_out,
  output logic                 count_valid,
  output logic                 wrap_pulse,
  output logic [ACC_WIDTH-1:0] total,
  output logic                 overflow
);

  localparam int RUN_W = 4;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

  logic [WIDTH-1:0]   s1;
  logic [WIDTH-1:0]   s2;
  logic [WIDTH-1:0]   cand;
  logic [RUN_W-1:0]   run;
  logic               same;
  logic               commit;
  logic               accumulate;
  logic [WIDTH-1:0]   delta;
  logic [ACC_WIDTH:0] sum;
  logic               saturate;

  // A commit is the edge on which run reaches STABLE_CYCLES; the very first
  // commit after reset only seeds count_out and does not accumulate.
  always_comb begin
    same       = (s2 == cand);
    commit     = same && (run == RUN_MAX - 1'b1);
    accumulate = commit && count_valid;
    delta      = cand - count_out;
    sum        = {1'b0, total} + (ACC_WIDTH+1)'(delta);
    saturate   = sum[ACC_WIDTH];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      cand <= '0;
      run  <= '0;
    end else begin
      s1 <= count_in;
      s2 <= s1;
      if (!same) begin
        cand <= s2;
        run  <= '0;
      end else if (run < RUN_MAX) begin
        run <= run + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_out   <= '0;
      count_valid <= 1'b0;
      wrap_pulse  <= 1'b0;
    end else begin
      wrap_pulse <= accumulate && (cand < count_out);
      if (commit) begin
        count_out   <= cand;
        count_valid <= 1'b1;
      end
    end
  end

  // Clear wins over a coincident commit: that commit's delta is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      total    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      total    <= '0;
      overflow <= 1'b0;
    end else if (accumulate) begin
      if (saturate) begin
        total    <= '1;
        overflow <= 1'b1;
      end else begin
        total <= sum[ACC_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor: a window-based model of the filter
// checked every cycle, plus literal expectations for the key scenarios.
module tb_ripple_count_monitor;

  localparam int W   = 4;
  localparam int SC  = 2;
  localparam int AWA = 16;
  localparam int AWB = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic           clear;
  logic [W-1:0]   count_in;

  logic [W-1:0]   count_out_a, count_out_b;
  logic           count_valid_a, count_valid_b;
  logic           wrap_pulse_a, wrap_pulse_b;
  logic [AWA-1:0] total_a;
  logic [AWB-1:0] total_b;
  logic           overflow_a, overflow_b;

  int n_checks = 0;
  int n_errors = 0;
  int wrap_cnt = 0;

  ripple_count_monitor #(.WIDTH(W), .STABLE_CYCLES(SC), .ACC_WIDTH(AWA)) dut_a (
    .clock(clock), .reset(reset), .count_in(count_in), .clear(clear),
    .count_out(count_out_a), .count_valid(count_valid_a), .wrap_pulse(wrap_pulse_a),
    .total(total_a), .overflow(overflow_a)
  );

  ripple_count_monitor #(.WIDTH(W), .STABLE_CYCLES(SC), .ACC_WIDTH(AWB)) dut_b (
    .clock(clock), .reset(reset), .count_in(count_in), .clear(clear),
    .count_out(count_out_b), .count_valid(count_valid_b), .wrap_pulse(wrap_pulse_b),
    .total(total_b), .overflow(overflow_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the value seen by the synchronizer output at each edge is count_in
  // from two edges earlier. A value is accepted when it has been seen on
  // SC+1 consecutive edges and was not seen on the edge just before that run.
  int     cin_q[$];
  int     hist[$];
  int     m_count[2];
  int     m_valid[2];
  int     m_wrap[2];
  longint m_total[2];
  int     m_ovf[2];
  longint acc_max[2];

  initial begin
    acc_max[0] = (longint'(1) << AWA) - 1;
    acc_max[1] = (longint'(1) << AWB) - 1;
  end

  always @(posedge clock or posedge reset) begin
    int     sv;
    int     n;
    bit     acc;
    int     delta;
    longint sum;
    if (reset) begin
      cin_q.delete();
      hist = '{-1, 0};
      for (int i = 0; i < 2; i++) begin
        m_count[i] = 0; m_valid[i] = 0; m_wrap[i] = 0; m_total[i] = 0; m_ovf[i] = 0;
      end
    end else begin
      sv = (cin_q.size() >= 2) ? cin_q[cin_q.size()-2] : 0;
      cin_q.push_back(int'(count_in));
      hist.push_back(sv);
      n = hist.size();
      acc = 1'b1;
      if (n < SC + 2) acc = 1'b0;
      else begin
        for (int j = 0; j <= SC; j++) if (hist[n-1-j] != sv) acc = 1'b0;
        if (hist[n-2-SC] == sv) acc = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        m_wrap[i] = 0;
        if (acc) begin
          if (m_valid[i] != 0) begin
            delta = (sv - m_count[i] + (1 << W)) % (1 << W);
            m_wrap[i] = (sv < m_count[i]) ? 1 : 0;
            if (!clear) begin
              sum = m_total[i] + delta;
              if (sum > acc_max[i]) begin
                m_total[i] = acc_max[i];
                m_ovf[i] = 1;
              end else begin
                m_total[i] = sum;
              end
            end
          end
          m_count[i] = sv;
          m_valid[i] = 1;
        end
        if (clear) begin
          m_total[i] = 0;
          m_ovf[i] = 0;
        end
      end
      if (hist.size() > 64) void'(hist.pop_front());
      if (cin_q.size() > 64) void'(cin_q.pop_front());
    end
  end

  always @(negedge clock) begin
    check("cmp_count_out_a",   count_out_a,   m_count[0]);
    check("cmp_count_valid_a", count_valid_a, m_valid[0]);
    check("cmp_wrap_pulse_a",  wrap_pulse_a,  m_wrap[0]);
    check("cmp_total_a",       total_a,       m_total[0]);
    check("cmp_overflow_a",    overflow_a,    m_ovf[0]);
    check("cmp_count_out_b",   count_out_b,   m_count[1]);
    check("cmp_count_valid_b", count_valid_b, m_valid[1]);
    check("cmp_wrap_pulse_b",  wrap_pulse_b,  m_wrap[1]);
    check("cmp_total_b",       total_b,       m_total[1]);
    check("cmp_overflow_b",    overflow_b,    m_ovf[1]);
  end

  always @(posedge clock) begin
    #2;
    if (wrap_pulse_a) wrap_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  int w0;

  initial begin
    reset    = 1'b1;
    clear    = 1'b0;
    count_in = '0;

    // reset with count_in = 0, then first commit of 0
    step(2);
    check("t1_reset_valid", count_valid_a, 0);
    check("t1_reset_total", total_a, 0);
    reset = 1'b0;
    step(3);
    check("t1_valid", count_valid_a, 1);
    check("t1_count", count_out_a, 0);
    check("t1_total", total_a, 0);

    // 0 -> 3, commit on the 5th edge after the change
    count_in = 4'd3;
    step(4);
    check("t2_count_before", count_out_a, 0);
    step(1);
    check("t2_count", count_out_a, 3);
    check("t2_total", total_a, 3);
    check("t2_wraps", wrap_cnt, 0);

    // one-cycle glitch to 7 is filtered
    count_in = 4'd7;
    step(1);
    count_in = 4'd3;
    step(8);
    check("t3_count", count_out_a, 3);
    check("t3_total", total_a, 3);
    check("t3_wraps", wrap_cnt, 0);

    // 3 -> 14 -> 2 wrap-around
    count_in = 4'd14;
    step(6);
    check("t4_count14", count_out_a, 14);
    check("t4_total14", total_a, 14);
    w0 = wrap_cnt;
    count_in = 4'd2;
    step(8);
    check("t4_count", count_out_a, 2);
    check("t4_total", total_a, 18);
    check("t4_wraps", wrap_cnt - w0, 1);
    check("t4_total_b", total_b, 15);
    check("t4_ovf_b", overflow_b, 1);

    // saturation on the 4-bit accumulator with steps 0 -> 8 -> 0 -> 8
    count_in = 4'd0;
    step(6);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("t5_clr_total_b", total_b, 0);
    check("t5_clr_ovf_b", overflow_b, 0);
    check("t5_clr_total_a", total_a, 0);
    count_in = 4'd8;
    step(6);
    check("t5_total_b_8", total_b, 8);
    count_in = 4'd0;
    step(6);
    count_in = 4'd8;
    step(6);
    check("t5_total_b", total_b, 15);
    check("t5_ovf_b", overflow_b, 1);
    check("t5_total_a", total_a, 24);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("t5_clear_total_b", total_b, 0);
    check("t5_clear_ovf_b", overflow_b, 0);
    check("t5_clear_count_b", count_out_b, 8);

    // clear coinciding with a commit discards that delta
    count_in = 4'd10;
    step(4);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("t5_sim_count", count_out_a, 10);
    check("t5_sim_total_a", total_a, 0);
    check("t5_sim_total_b", total_b, 0);

    // reset between edges while a new value is pending
    count_in = 4'd0;
    step(3);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_count", count_out_a, 0);
    check("t6_async_valid", count_valid_a, 0);
    check("t6_async_total", total_b, 0);
    check("t6_async_ovf", overflow_b, 0);
    step(2);
    reset = 1'b0;
    step(1);
    check("t6_valid_early", count_valid_a, 0);
    step(1);
    check("t6_valid", count_valid_a, 1);
    check("t6_count", count_out_a, 0);
    check("t6_total", total_a, 0);
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
